// File: rtl/i2c_burst_reader.sv
// rtl/i2c_burst_reader.sv - I2C master: write register pointer, repeated START, burst read
// Optional macro I2C_SDA_SYNC_EN adds a two-flop synchronizer on SDA_in.
module i2c_burst_reader #(
   parameter int CLK_DIV = 250,
   parameter int MAX_LEN = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [6:0] dev_addr,
   input  logic [7:0] reg_addr,
   input  logic [3:0] len,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       SCL,
   input  logic       SDA_in,
   output logic       SDA_out,
   output logic       SDA_oen
);

   typedef enum logic [3:0] {
      IDLE, START, WADDR, WACK1, REG, WACK2, RSTART, RADDR, WACK3, READ, MACK, STOP
   } state_t;

   localparam logic [9:0] QLAST    = 10'(CLK_DIV - 1);
   localparam logic [3:0] MAX_LEN4 = 4'(MAX_LEN);

   state_t     state, state_n;
   logic [9:0] qcnt;
   logic [1:0] qtr;
   logic [2:0] bcnt;
   logic [3:0] byte_idx;
   logic [3:0] len_r;
   logic [3:0] len_clamp;
   logic [6:0] dev_r;
   logic [7:0] reg_r;
   logic [7:0] tx_byte;
   logic [7:0] rx_sh;
   logic       ack_smp;
   logic       sda_src;
   logic       tick, sample, bit_end, accept, last_byte;
   logic       scl_d, sda_d, oen_d;

`ifdef I2C_SDA_SYNC_EN
   logic [1:0] sda_sync;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sda_sync <= 2'b11;
      else      sda_sync <= {sda_sync[0], SDA_in};
   end

   assign sda_src = sda_sync[1];
`else
   assign sda_src = SDA_in;
`endif

   assign tick      = (state != IDLE) && (qcnt == QLAST);
   assign sample    = tick && (qtr == 2'd2);
   assign bit_end   = tick && (qtr == 2'd3);
   assign accept    = (state == IDLE) && start;
   assign last_byte = ((byte_idx + 4'd1) == len_r);
   assign len_clamp = (len > MAX_LEN4) ? MAX_LEN4 : len;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_n;
   end

   // Bus levels per state and quarter; registered below so SCL/SDA never glitch.
   always_comb begin
      state_n = state;
      scl_d   = 1'b1;
      sda_d   = 1'b1;
      oen_d   = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_n = START;
         end
         START: begin
            oen_d = 1'b1;
            sda_d = ~qtr[1];
            if (bit_end) state_n = WADDR;
         end
         WADDR, REG, RADDR: begin
            scl_d = qtr[1];
            oen_d = 1'b1;
            sda_d = tx_byte[3'd7 - bcnt];
            if (bit_end && bcnt == 3'd7) begin
               if (state == WADDR)    state_n = WACK1;
               else if (state == REG) state_n = WACK2;
               else                   state_n = WACK3;
            end
         end
         WACK1, WACK2, WACK3: begin
            scl_d = qtr[1];
            if (bit_end) begin
               if (ack_smp)             state_n = STOP;
               else if (state == WACK1) state_n = REG;
               else if (state == WACK2) state_n = (len_r == 4'd0) ? STOP : RSTART;
               else                     state_n = READ;
            end
         end
         RSTART: begin
            // SCL must be low first so SDA can rise before the high-phase fall.
            scl_d = (qtr != 2'd0);
            oen_d = 1'b1;
            sda_d = ~qtr[1];
            if (bit_end) state_n = RADDR;
         end
         READ: begin
            scl_d = qtr[1];
            if (bit_end && bcnt == 3'd7) state_n = MACK;
         end
         MACK: begin
            scl_d = qtr[1];
            oen_d = ~last_byte;
            sda_d = last_byte;
            if (bit_end) state_n = last_byte ? STOP : READ;
         end
         STOP: begin
            scl_d = (qtr != 2'd0);
            oen_d = 1'b1;
            sda_d = qtr[1];
            if (bit_end) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         qcnt     <= '0;
         qtr      <= '0;
         bcnt     <= '0;
         byte_idx <= '0;
         len_r    <= '0;
         dev_r    <= '0;
         reg_r    <= '0;
         tx_byte  <= '0;
         rx_sh    <= '0;
         ack_smp  <= 1'b0;
         done     <= 1'b0;
         ack_err  <= 1'b0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
         SCL      <= 1'b1;
         SDA_out  <= 1'b1;
         SDA_oen  <= 1'b0;
      end else begin
         done     <= 1'b0;
         rd_valid <= 1'b0;
         SCL      <= scl_d;
         SDA_out  <= sda_d;
         SDA_oen  <= oen_d;
         if (accept) begin
            qcnt     <= '0;
            qtr      <= '0;
            bcnt     <= '0;
            byte_idx <= '0;
            len_r    <= len_clamp;
            dev_r    <= dev_addr;
            reg_r    <= reg_addr;
            tx_byte  <= {dev_addr, 1'b0};
            ack_err  <= 1'b0;
         end else if (state != IDLE) begin
            if (tick) begin
               qcnt <= '0;
               qtr  <= qtr + 2'd1;
            end else begin
               qcnt <= qcnt + 10'd1;
            end
            if (sample) begin
               ack_smp <= sda_src;
               rx_sh   <= {rx_sh[6:0], sda_src};
               if (state == READ && bcnt == 3'd7) begin
                  rd_data  <= {rx_sh[6:0], sda_src};
                  rd_valid <= 1'b1;
               end
            end
            if (bit_end) begin
               case (state)
                  WADDR, REG, RADDR, READ: bcnt <= bcnt + 3'd1;
                  WACK1: begin
                     tx_byte <= reg_r;
                     if (ack_smp) ack_err <= 1'b1;
                  end
                  WACK2, WACK3: begin
                     if (ack_smp) ack_err <= 1'b1;
                  end
                  RSTART: tx_byte <= {dev_r, 1'b1};
                  MACK:   byte_idx <= byte_idx + 4'd1;
                  STOP:   done <= 1'b1;
                  default: ;
               endcase
            end
         end
      end
   end

endmodule
